rasterizer: RTL and testbench
=============================

RASTERIZER -- requirements
Module: rasterizer

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 214, framebuffer width in pixels.
REQ-002 SHALL have parameter FB_HEIGHT, default 160, framebuffer height in pixels.
REQ-003 SHALL have parameter A_WIDTH, default 16, framebuffer address width.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_async  input  1  asynchronous, active-high reset.
REQ-006 cmd_valid  input  1  fill-rectangle command present.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_x0, cmd_x1  input  8 each  inclusive column bounds.
REQ-009 cmd_y0, cmd_y1  input  8 each  inclusive row bounds.
REQ-010 cmd_color  input  3  pixel value {r,g,b}.
REQ-011 fb_write_en  output  1  framebuffer write strobe.
REQ-012 fb_write_addr  output  A_WIDTH  pixel address, y*FB_WIDTH+x.
REQ-013 fb_write_data  output  3  pixel value.
REQ-014 busy  output  1  fill in progress.
REQ-015 done  output  1  one-cycle pulse at command completion.

Function
REQ-016 SHALL implement states IDLE and FILL; cmd_ready = (state==IDLE); busy = (state==FILL).
REQ-017 SHALL accept a command on a clock edge where cmd_valid && cmd_ready, registering all cmd_* fields; cmd_* ignored at all other times.
REQ-018 On acceptance with x0<=x1 and y0<=y1 (after clipping when enabled), SHALL enter FILL; first fb_write_en in the cycle immediately after acceptance.
REQ-019 In FILL SHALL assert fb_write_en every cycle, one pixel per cycle, row-major: x from x0 to x1, then y+1 and x back to x0, until (x1,y1) written.
REQ-020 SHALL form the address without a multiplier: row base starts at y0*FB_WIDTH (computed by repeated add or constant shift-add), increments by FB_WIDTH per row; addr = row base + x.
REQ-021 A command of W columns by H rows SHALL produce exactly W*H writes in W*H consecutive cycles, no gaps, no duplicates.
REQ-022 fb_write_data SHALL equal the registered cmd_color for every write of that command.
REQ-023 SHALL return to IDLE and pulse done for one cycle in the cycle after the last write; cmd_ready high in that same cycle.
REQ-024 On acceptance with x0>x1 or y0>y1, SHALL perform no writes, stay in IDLE, and pulse done in the next cycle.
REQ-025 Back-to-back: a command accepted in the done cycle SHALL begin writing the following cycle (one idle cycle between commands).
REQ-026 fb_write_en SHALL be 0 whenever state is IDLE; fb_write_addr/fb_write_data don't-care when fb_write_en=0.

Reset
REQ-027 Assertion of rst_async SHALL immediately force state=IDLE, fb_write_en=0, done=0, busy=0, cmd_ready=1, fb_write_addr=0, fb_write_data=0.
REQ-028 Reset mid-FILL SHALL abandon the command with no further writes and no done pulse.
REQ-029 First command SHALL be acceptable on the first rising edge after deassertion.

Configuration
REQ-030 Macro RASTERIZER_CLIP_EN: when defined, on acceptance x0,x1 clamp to FB_WIDTH-1 and y0,y1 to FB_HEIGHT-1 before REQ-018/REQ-024 evaluation, so no address >= FB_WIDTH*FB_HEIGHT is emitted.
REQ-031 When RASTERIZER_CLIP_EN is undefined, coordinates SHALL be used unmodified; addresses wrap modulo 2^A_WIDTH; in-bounds coordinates are the caller's responsibility.

Verification
REQ-032 Single pixel (5,7)-(5,7), color 3 -> one write, addr 1503, data 3; done next cycle.
REQ-033 Rect (0,0)-(1,1), color 5 -> writes addr 0,1,214,215 on 4 consecutive cycles, then done.
REQ-034 Full screen (0,0)-(213,159), color 7 -> 34240 contiguous writes, addrs 0..34239 in order, single done.
REQ-035 Inverted (10,0)-(3,0) -> zero writes, done pulse the cycle after acceptance, cmd_ready stays 1.
REQ-036 CLIP_EN defined, (210,158)-(250,200) -> 8 writes: 34022..34025 then 34236..34239; CLIP_EN undefined: no clamping, 41 columns per row.
REQ-037 Reset asserted on 3rd write of (0,0)-(9,0) -> fb_write_en drops immediately, no done, cmd_ready=1; next command completes normally.

Source files
------------

// File: rtl/rasterizer.sv
// rtl/rasterizer.sv - fill-rectangle rasterizer, one pixel per cycle; optional clamping via RASTERIZER_CLIP_EN
module rasterizer #(
    parameter int FB_WIDTH  = 214,
    parameter int FB_HEIGHT = 160,
    parameter int A_WIDTH   = 16
) (
    input  logic               clk,
    input  logic               rst_async,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [7:0]         cmd_x0,
    input  logic [7:0]         cmd_x1,
    input  logic [7:0]         cmd_y0,
    input  logic [7:0]         cmd_y1,
    input  logic [2:0]         cmd_color,
    output logic               fb_write_en,
    output logic [A_WIDTH-1:0] fb_write_addr,
    output logic [2:0]         fb_write_data,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t state_q, state_d;

    logic [7:0]         x_q, y_q, x0_q, x1_q, y1_q;
    logic [A_WIDTH-1:0] row_q;
    logic [2:0]         color_q;
    logic               done_q;

    logic [7:0] x0_c, x1_c, y0_c, y1_c;
    logic       accept, empty, row_end, last_px;

    // y * FB_WIDTH as a sum of shifted copies of the constant width
    function automatic logic [A_WIDTH-1:0] row_base(input logic [7:0] y);
        logic [A_WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) begin
                acc = acc + (A_WIDTH'(FB_WIDTH) << i);
            end
        end
        return acc;
    endfunction

`ifdef RASTERIZER_CLIP_EN
    localparam logic [7:0] X_MAX = 8'(FB_WIDTH - 1);
    localparam logic [7:0] Y_MAX = 8'(FB_HEIGHT - 1);

    function automatic logic [7:0] clamp(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // Clamp incoming coordinates to the framebuffer before range checks
    always_comb begin
        x0_c = clamp(cmd_x0, X_MAX);
        x1_c = clamp(cmd_x1, X_MAX);
        y0_c = clamp(cmd_y0, Y_MAX);
        y1_c = clamp(cmd_y1, Y_MAX);
    end
`else
    // Coordinates pass through untouched; caller keeps them in bounds
    always_comb begin
        x0_c = cmd_x0;
        x1_c = cmd_x1;
        y0_c = cmd_y0;
        y1_c = cmd_y1;
    end
`endif

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == FILL);
    assign accept    = cmd_valid && cmd_ready;
    assign empty     = (x0_c > x1_c) || (y0_c > y1_c);
    assign row_end   = (x_q == x1_q);
    assign last_px   = row_end && (y_q == y1_q);

    assign fb_write_en   = (state_q == FILL);
    assign fb_write_addr = row_q + A_WIDTH'(x_q);
    assign fb_write_data = color_q;
    assign done          = done_q;

    // State register
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter FILL on a non-empty command, leave after the last pixel
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && !empty) state_d = FILL;
            FILL: if (last_px) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command capture, row-major pixel walk and done pulse
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            row_q   <= '0;
            color_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                x_q     <= x0_c;
                y_q     <= y0_c;
                x0_q    <= x0_c;
                x1_q    <= x1_c;
                y1_q    <= y1_c;
                row_q   <= row_base(y0_c);
                color_q <= cmd_color;
                done_q  <= empty;
            end else if (state_q == FILL) begin
                if (last_px) begin
                    done_q <= 1'b1;
                end else if (row_end) begin
                    x_q   <= x0_q;
                    y_q   <= y_q + 8'd1;
                    row_q <= row_q + A_WIDTH'(FB_WIDTH);
                end else begin
                    x_q <= x_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rasterizer.sv
// tb/tb_rasterizer.sv - self-checking bench for rasterizer against a rectangle-enumeration model
module tb_rasterizer;

    localparam int FB_WIDTH  = 214;
    localparam int FB_HEIGHT = 160;
    localparam int A_WIDTH   = 16;

    logic               clk;
    logic               rst_async;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [7:0]         cmd_x0, cmd_x1, cmd_y0, cmd_y1;
    logic [2:0]         cmd_color;
    logic               fb_write_en;
    logic [A_WIDTH-1:0] fb_write_addr;
    logic [2:0]         fb_write_data;
    logic               busy;
    logic               done;

    int errors = 0;
    int checks = 0;

    rasterizer #(
        .FB_WIDTH (FB_WIDTH),
        .FB_HEIGHT(FB_HEIGHT),
        .A_WIDTH  (A_WIDTH)
    ) dut (
        .clk          (clk),
        .rst_async    (rst_async),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_x0       (cmd_x0),
        .cmd_x1       (cmd_x1),
        .cmd_y0       (cmd_y0),
        .cmd_y1       (cmd_y1),
        .cmd_color    (cmd_color),
        .fb_write_en  (fb_write_en),
        .fb_write_addr(fb_write_addr),
        .fb_write_data(fb_write_data),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: list every pixel address of the rectangle in row-major order
    function automatic void model(input int x0, input int x1, input int y0, input int y1,
                                  output logic [A_WIDTH-1:0] q[$]);
        q = {};
`ifdef RASTERIZER_CLIP_EN
        if (x0 > FB_WIDTH - 1)  x0 = FB_WIDTH - 1;
        if (x1 > FB_WIDTH - 1)  x1 = FB_WIDTH - 1;
        if (y0 > FB_HEIGHT - 1) y0 = FB_HEIGHT - 1;
        if (y1 > FB_HEIGHT - 1) y1 = FB_HEIGHT - 1;
`endif
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                q.push_back(A_WIDTH'((y * FB_WIDTH + x) % (1 << A_WIDTH)));
    endfunction

    // Called at a negedge with the DUT ready; returns at the negedge of the done cycle
    task automatic run_cmd(input string tag, input int x0, input int x1, input int y0, input int y1,
                           input logic [2:0] c);
        logic [A_WIDTH-1:0] q[$];
        model(x0, x1, y0, y1, q);
        check({tag, " ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_x0 = 8'(x0); cmd_x1 = 8'(x1); cmd_y0 = 8'(y0); cmd_y1 = 8'(y1);
        cmd_color = c;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_x0 = 8'($urandom); cmd_x1 = 8'($urandom);
        cmd_y0 = 8'($urandom); cmd_y1 = 8'($urandom);
        cmd_color = 3'($urandom);
        foreach (q[i]) begin
            check({tag, " write"},
                  32'({fb_write_en, done, busy, cmd_ready, fb_write_addr, fb_write_data}),
                  32'({1'b1, 1'b0, 1'b1, 1'b0, q[i], c}));
            @(negedge clk);
        end
        check({tag, " done"}, 32'({fb_write_en, done, busy, cmd_ready}), 32'(4'b0101));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check("idle", 32'({fb_write_en, done, busy, cmd_ready}), 32'(4'b0001));
        end
    endtask

    initial begin
        int rx0, rx1, ry0, ry1, t;
        rst_async = 1'b1;
        cmd_valid = 1'b0;
        cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0;
        cmd_color = '0;
        repeat (3) @(negedge clk);
        check("reset state",
              32'({fb_write_en, done, busy, cmd_ready, fb_write_addr, fb_write_data}),
              32'({4'b0001, 16'd0, 3'd0}));
        rst_async = 1'b0;

        // First command on the first edge after reset release, then back-to-back
        run_cmd("pixel", 5, 5, 7, 7, 3'd3);
        run_cmd("rect2x2", 0, 1, 0, 1, 3'd5);
        idle(2);
        run_cmd("inverted", 10, 3, 0, 0, 3'd2);
        idle(1);
        run_cmd("clipcase", 210, 250, 158, 200, 3'd6);
        idle(1);
        run_cmd("fullscreen", 0, FB_WIDTH - 1, 0, FB_HEIGHT - 1, 3'd7);
        idle(1);

        // Reset during the third write of a 10-pixel row
        cmd_valid = 1'b1;
        cmd_x0 = 8'd0; cmd_x1 = 8'd9; cmd_y0 = 8'd0; cmd_y1 = 8'd0; cmd_color = 3'd4;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("pre-reset write", 32'({fb_write_en, fb_write_addr, fb_write_data}),
                  32'({1'b1, 16'(i), 3'd4}));
            if (i < 2) @(negedge clk);
        end
        rst_async = 1'b1;
        #1;
        check("mid-fill reset",
              32'({fb_write_en, done, busy, cmd_ready, fb_write_addr, fb_write_data}),
              32'({4'b0001, 16'd0, 3'd0}));
        @(negedge clk);
        rst_async = 1'b0;
        idle(12);
        run_cmd("after reset", 3, 6, 2, 3, 3'd1);

        // Random rectangles, mixing back-to-back issue, gaps and inverted bounds
        for (int n = 0; n < 30; n++) begin
            rx0 = $urandom_range(0, FB_WIDTH - 1);
            rx1 = rx0 + $urandom_range(0, 12);
            if (rx1 > FB_WIDTH - 1) rx1 = FB_WIDTH - 1;
            ry0 = $urandom_range(0, FB_HEIGHT - 1);
            ry1 = ry0 + $urandom_range(0, 6);
            if (ry1 > FB_HEIGHT - 1) ry1 = FB_HEIGHT - 1;
            if ($urandom_range(0, 5) == 0) begin
                t = rx0; rx0 = rx1 + 1; rx1 = t;
                if (rx0 > 255) rx0 = 255;
            end
            run_cmd("random", rx0, rx1, ry0, ry1, 3'($urandom));
            idle($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
